ps2_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs followed by the LED mask, or 0xFF reset.
- Shares the open-drain keyboard clock and data lines with the existing scan-code receive path.
- Drives `tx_idle`, which gates the receiver's `rx_en` so that no frame is captured while a transmission is in progress.

---
 rtl/ps2_tx.sv | 191 +++++++++++++++++++
 tb/tb_ps2_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
`timescale 1ns / 1ps
// PS/2 host-to-device transmitter.
// Sends one byte (start, 8 data LSB first, odd parity, stop) and checks the device ACK.
// Optional watchdog on the device clock: define PS2_TX_TIMEOUT_EN.
module ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err
);

  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRts,
    StStart,
    StData,
    StStop,
    StWaitRel
  } state_e;

  state_e                  state_q;
  logic [FILTER_LEN-1:0]   filt_q;
  logic                    fclk_q, fclk_d;
  logic [1:0]              dsync_q;
  logic                    ps2d_s;
  logic                    fall_edge;
  logic [8:0]              sreg_q;
  logic [InhW-1:0]         cnt_q;
  logic [3:0]              bitcnt_q;
  logic                    ack_ok_q;
  logic                    tmo_hit;

  assign ps2d_s = dsync_q[1];

  // Filtered clock only changes once the whole window agrees; otherwise it holds.
  always_comb begin
    fclk_d = fclk_q;
    if (filt_q == '1) begin
      fclk_d = 1'b1;
    end else if (filt_q == '0) begin
      fclk_d = 1'b0;
    end
    fall_edge = fclk_q & ~fclk_d;
  end

  // Clock glitch filter and data-line synchroniser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q  <= '1;
      fclk_q  <= 1'b1;
      dsync_q <= 2'b11;
    end else begin
      filt_q  <= {ps2c_in, filt_q[FILTER_LEN-1:1]};
      fclk_q  <= fclk_d;
      dsync_q <= {dsync_q[0], ps2d_in};
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_q;
  logic            tmo_active;

  assign tmo_active = (state_q == StStart) || (state_q == StData) ||
                      (state_q == StStop)  || (state_q == StWaitRel);
  assign tmo_hit    = tmo_active && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  // Watchdog: restarts on every device clock edge while a frame is on the wire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else if (!tmo_active || fall_edge) begin
      tmo_q <= '0;
    end else if (!tmo_hit) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign tmo_hit            = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Transmit FSM with registered line drivers and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      sreg_q       <= '0;
      cnt_q        <= '0;
      bitcnt_q     <= '0;
      ack_ok_q     <= 1'b0;
      ps2c_oe      <= 1'b0;
      ps2d_oe      <= 1'b0;
      tx_idle      <= 1'b1;
      tx_done_tick <= 1'b0;
      ack_err      <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      ack_err      <= 1'b0;
      case (state_q)
        StIdle: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          tx_idle <= 1'b1;
          if (wr_ps2) begin
            sreg_q  <= {~^din, din};
            cnt_q   <= '0;
            ps2c_oe <= 1'b1;
            tx_idle <= 1'b0;
            state_q <= StRts;
          end
        end
        StRts: begin
          if (cnt_q == InhLast) begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b1;
            state_q <= StStart;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStart: begin
          if (fall_edge) begin
            ps2d_oe  <= ~sreg_q[0];
            bitcnt_q <= 4'd8;
            state_q  <= StData;
          end
        end
        StData: begin
          if (fall_edge) begin
            if (bitcnt_q == 4'd0) begin
              // Parity has been sampled; releasing the line forms the stop bit.
              ps2d_oe <= 1'b0;
              state_q <= StStop;
            end else begin
              sreg_q   <= {1'b0, sreg_q[8:1]};
              ps2d_oe  <= ~sreg_q[1];
              bitcnt_q <= bitcnt_q - 1'b1;
            end
          end
        end
        StStop: begin
          ps2d_oe <= 1'b0;
          if (fall_edge) begin
            ack_ok_q <= ~ps2d_s;
            ack_err  <= ps2d_s;
            state_q  <= StWaitRel;
          end
        end
        StWaitRel: begin
          if (fclk_q && ps2d_s) begin
            tx_done_tick <= ack_ok_q;
            tx_idle      <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          tx_idle <= 1'b1;
          state_q <= StIdle;
        end
      endcase
      if (tmo_hit) begin
        ps2c_oe      <= 1'b0;
        ps2d_oe      <= 1'b0;
        tx_idle      <= 1'b1;
        tx_done_tick <= 1'b0;
        ack_err      <= 1'b1;
        state_q      <= StIdle;
      end
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
`timescale 1ns / 1ps
// Directed bench for ps2_tx with an open-drain keyboard model.
module tb_ps2_tx;

  localparam int unsigned Inhibit = 5000;
  localparam int unsigned Timeout = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       bfm_c = 1'b1;
  logic       bfm_d = 1'b1;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, ack_err;

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic both_seen = 1'b0;

  // Wired-AND bus: either side may pull a line low.
  assign ps2c_in = ~ps2c_oe & bfm_c;
  assign ps2d_in = ~ps2d_oe & bfm_d;

  always #5 clk = ~clk;

  ps2_tx #(
    .INHIBIT_CYCLES(Inhibit),
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .ps2c_in     (ps2c_in),
    .ps2d_in     (ps2d_in),
    .ps2c_oe     (ps2c_oe),
    .ps2d_oe     (ps2d_oe),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .ack_err     (ack_err)
  );

  always @(negedge clk) begin
    if (tx_done_tick) done_cnt <= done_cnt + 1;
    if (ack_err) err_cnt <= err_cnt + 1;
    if (tx_done_tick && ack_err) both_seen <= 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue a request and count how many clk the clock line is held in inhibit.
  task automatic start_tx(input logic [7:0] b, output int hi_cnt);
    din    = b;
    wr_ps2 = 1'b1;
    cyc(1);
    wr_ps2 = 1'b0;
    din    = 8'h00;
    hi_cnt = 0;
    while (ps2c_oe === 1'b1 && hi_cnt < Inhibit + 1000) begin
      hi_cnt++;
      cyc(1);
    end
  endtask

  // Keyboard model: 11 clock pulses, bits sampled at the rising edge.
  task automatic bfm_frame(input logic ack, input int inject_at, input int abort_at,
                           output logic [10:0] frm);
    int t;
    frm = '0;
    cyc(30);
    frm[0] = ps2d_in;
    for (int k = 1; k <= 11; k++) begin
      bfm_c = 1'b0;
      if (k == abort_at) begin
        cyc(12);
        check("abort_pre_d_oe", ps2d_oe, 1);
        rst = 1'b0;
        #1;
        check("abort_c_oe", ps2c_oe, 0);
        check("abort_d_oe", ps2d_oe, 0);
        check("abort_idle", tx_idle, 1);
        cyc(2);
        rst   = 1'b1;
        bfm_c = 1'b1;
        bfm_d = 1'b1;
        return;
      end
      if (k == inject_at) begin
        din    = 8'hFF;
        wr_ps2 = 1'b1;
        cyc(1);
        wr_ps2 = 1'b0;
        cyc(19);
      end else begin
        cyc(20);
      end
      bfm_c = 1'b1;
      if (k <= 10) frm[k] = ps2d_in;
      if (k == 10 && ack) begin
        cyc(10);
        bfm_d = 1'b0;
        cyc(10);
      end else begin
        cyc(20);
      end
    end
    bfm_d = 1'b1;
    t = 0;
    while (!tx_idle && t < 200) begin
      cyc(1);
      t++;
    end
  endtask

  task automatic full_tx(input string tag, input logic [7:0] b, input logic ack,
                         input int inject_at, input logic [10:0] exp_frm,
                         input int exp_done, input int exp_err);
    int hi;
    int d0, e0;
    logic [10:0] frm;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(b, hi);
    check({tag, "_inhibit"}, hi, Inhibit);
    check({tag, "_start_d_oe"}, ps2d_oe, 1);
    check({tag, "_busy"}, tx_idle, 0);
    bfm_frame(ack, inject_at, 0, frm);
    check({tag, "_frame"}, {21'b0, frm}, {21'b0, exp_frm});
    check({tag, "_idle"}, tx_idle, 1);
    cyc(2);
    check({tag, "_done"}, done_cnt - d0, exp_done);
    check({tag, "_err"}, err_cnt - e0, exp_err);
  endtask

  initial begin
    int hi, d0, e0, t;
    logic [10:0] frm;

    // Reset state
    cyc(3);
    check("rst_c_oe", ps2c_oe, 0);
    check("rst_d_oe", ps2d_oe, 0);
    check("rst_idle", tx_idle, 1);
    check("rst_done", tx_done_tick, 0);
    check("rst_err", ack_err, 0);
    rst = 1'b1;
    cyc(5);

    // 0xED: six ones -> parity 1; frame {stop,par,data,start} = 0x7DA
    full_tx("ed", 8'hED, 1'b1, 0, 11'h7DA, 1, 0);

    // 0x07 with a 0xFF request injected mid-frame: parity 0 -> 0x40E
    full_tx("x07", 8'h07, 1'b1, 3, 11'h40E, 1, 0);
    cyc(50);
    check("noqueue_idle", tx_idle, 1);
    check("noqueue_c_oe", ps2c_oe, 0);
    din = 8'h00;

    // 0x00: parity 1 -> 0x600
    full_tx("x00", 8'h00, 1'b1, 0, 11'h600, 1, 0);

    // 0x55 without ACK: parity 1 -> 0x6AA, error pulse only
    full_tx("nack", 8'h55, 1'b0, 0, 11'h6AA, 0, 1);

    // 0xAA aborted by reset at the 5th falling edge
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hAA, hi);
    bfm_frame(1'b1, 0, 5, frm);
    cyc(20);
    check("abort_idle_after", tx_idle, 1);
    check("abort_done", done_cnt - d0, 0);
    check("abort_err", err_cnt - e0, 0);

    // 0xF4 after the abort: five ones -> parity 0 -> 0x5E8
    full_tx("f4", 8'hF4, 1'b1, 0, 11'h5E8, 1, 0);

    // Absent device: no clock pulses after the inhibit
    e0 = err_cnt;
    start_tx(8'h12, hi);
`ifdef PS2_TX_TIMEOUT_EN
    t = 0;
    while (!tx_idle && t < Timeout + 200) begin
      cyc(1);
      t++;
    end
    check("tmo_window", (t > Timeout - 20 && t < Timeout + 20) ? 1 : 0, 1);
    check("tmo_idle", tx_idle, 1);
    check("tmo_c_oe", ps2c_oe, 0);
    check("tmo_d_oe", ps2d_oe, 0);
    cyc(2);
    check("tmo_err", err_cnt - e0, 1);
`else
    t = 0;
    cyc(Timeout + 1000);
    check("stuck_busy", tx_idle, 0);
    check("stuck_d_oe", ps2d_oe, 1);
    check("stuck_c_oe", ps2c_oe, 0);
    check("stuck_err", err_cnt - e0, 0);
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(2);
    check("stuck_recover", tx_idle, 1);
`endif

    check("exclusive_pulses", both_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
